init: RTL and testbench

- Fills the 256-entry ARC4 state array S so that S[k] = k for k = 0..255.
- Drives the write port of a 256x8 single-port memory via addr/wrdata/wren.
- Uses a rdy/en request handshake towards the ARC4 top-level controller.
- Sits before the key-scheduling stage.

---
 rtl/arc4_pkg.sv | 13 +
 rtl/init_if.sv | 27 ++
 rtl/init.sv | 92 +++++++++
 tb/tb_init.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: state-array depth and the
// init/ksa/prga sequencing states.
package arc4_pkg;

  localparam int S_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } arc4_state_t;

endpackage

// File: rtl/init_if.sv
// init request handshake (en/rdy) plus the S-memory write port.
// slave: init block side; master: controller/memory side.
interface init_if;

  logic       en;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;

  modport slave (
    input  en,
    output rdy,
    output addr,
    output wrdata,
    output wren
  );

  modport master (
    output en,
    input  rdy,
    input  addr,
    input  wrdata,
    input  wren
  );

endinterface

// File: rtl/init.sv
// Fills S[k]=k, k=0..255, one write per clock after an accepted en.
// Ports: clk, rst_n (async low), bus (en/rdy, addr/wrdata/wren).
module init
  import arc4_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  init_if.slave  bus
);

  arc4_state_t state, state_n;

  // 9 bits so the count can reach 256 without wrapping.
  logic [8:0] i, i_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wrdata_q, wrdata_n;
  logic       wren_q, wren_n;
  logic       rdy_q, rdy_n;

  localparam logic [8:0] LAST = 9'(S_DEPTH);

  always_comb begin
    state_n  = state;
    i_n      = i;
    addr_n   = addr_q;
    wrdata_n = wrdata_q;
    wren_n   = wren_q;
    rdy_n    = rdy_q;
    unique case (state)
      IDLE: begin
        rdy_n  = 1'b1;
        wren_n = 1'b0;
        if (bus.en) begin
          state_n  = WRITE;
          addr_n   = 8'd0;
          wrdata_n = 8'd0;
          wren_n   = 1'b1;
          i_n      = 9'd1;
          rdy_n    = 1'b0;
        end
      end
      WRITE: begin
        rdy_n = 1'b0;
        if (i == LAST) begin
          wren_n  = 1'b0;
          state_n = DONE;
        end else begin
          addr_n   = i[7:0];
          wrdata_n = i[7:0];
          wren_n   = 1'b1;
          i_n      = i + 9'd1;
        end
      end
      DONE: begin
        wren_n  = 1'b0;
        rdy_n   = 1'b1;
        i_n     = 9'd0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
        wren_n  = 1'b0;
        i_n     = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= 9'd0;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state    <= state_n;
      i        <= i_n;
      addr_q   <= addr_n;
      wrdata_q <= wrdata_n;
      wren_q   <= wren_n;
      rdy_q    <= rdy_n;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;

endmodule

// File: tb/tb_init.sv
// Directed bench for init: reset, full fill, en handling,
// mid-run reset, and a behavioural S memory.
module tb_init;

  logic clk;
  logic rst_n;
  logic clk_on;
  int   checks;
  int   failures;
  int   wcnt;
  logic [7:0] mem [256];

  init_if bus ();

  init dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.wren === 1'b1) begin
      mem[bus.addr] = bus.wrdata;
      wcnt = wcnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++)
      mem[k] = 8'(k) ^ 8'hff;
    wcnt = 0;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (bus.rdy !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, int'(bus.rdy === 1'b1), 1);
  endtask

  task automatic chk_out(input string tag,
                         input int ei,
                         input int ea,
                         input int ew,
                         input int er);
    chk({tag, "_i"}, int'(dut.i), ei);
    chk({tag, "_addr"}, int'(bus.addr), ea);
    chk({tag, "_wrdata"}, int'(bus.wrdata), ea);
    chk({tag, "_wren"}, int'(bus.wren), ew);
    chk({tag, "_rdy"}, int'(bus.rdy), er);
  endtask

  initial begin
    int bad;
    checks   = 0;
    failures = 0;
    wcnt     = 0;
    clk_on   = 1'b0;
    bus.en   = 1'b0;
    rst_n    = 1'b1;
    clear_mem();

    // async reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst", 0, 0, 0, 1);
    #5 rst_n = 1'b1;
    clk_on = 1'b1;
    tick();
    tick();
    chk_out("idle", 0, 0, 0, 1);

    // full run with one-cycle en
    clear_mem();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk_out("e1", 1, 0, 1, 0);
    bad = 0;
    for (int k = 2; k <= 256; k++) begin
      tick();
      if (dut.i !== 9'(k) || bus.addr !== 8'(k - 1) ||
          bus.wrdata !== 8'(k - 1) || bus.wren !== 1'b1 ||
          bus.rdy !== 1'b0)
        bad++;
    end
    chk("run_seq", bad, 0);
    chk_out("e256", 256, 255, 1, 0);
    tick();
    chk("e257_wren", int'(bus.wren), 0);
    chk("e257_rdy", int'(bus.rdy), 0);
    tick();
    chk("e258_rdy", int'(bus.rdy), 1);
    chk("e258_i", int'(dut.i), 0);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== 8'(k)) bad++;
    chk("mem_bad", bad, 0);
    chk("mem_wcnt", wcnt, 256);

    // en held high: one run, restart only after rdy
    clear_mem();
    bus.en = 1'b1;
    tick();
    chk_out("h1", 1, 0, 1, 0);
    for (int k = 2; k <= 256; k++) tick();
    chk_out("h256", 256, 255, 1, 0);
    tick();
    chk("h257_rdy", int'(bus.rdy), 0);
    chk("h257_wren", int'(bus.wren), 0);
    tick();
    chk("h258_rdy", int'(bus.rdy), 1);
    chk("h258_i", int'(dut.i), 0);
    chk("h258_wcnt", wcnt, 256);
    tick();
    chk_out("h259", 1, 0, 1, 0);
    bus.en = 1'b0;
    wait_rdy("h_done");

    // en pulsed mid-run does not restart
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int k = 2; k <= 101; k++) tick();
    chk("p_at100", int'(bus.addr), 100);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("p_101", int'(bus.addr), 101);
    chk("p_i", int'(dut.i), 102);
    tick();
    chk("p_102", int'(bus.addr), 102);
    chk("p_wren", int'(bus.wren), 1);
    wait_rdy("p_done");

    // reset mid-run at addr=50
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int k = 2; k <= 51; k++) tick();
    chk("r_at50", int'(bus.addr), 50);
    #1 rst_n = 1'b0;
    #1;
    chk_out("r_rst", 0, 0, 0, 1);
    #1 rst_n = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk_out("r_new", 1, 0, 1, 0);
    wait_rdy("r_done");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
